// File: rtl/word_reg_file.sv
// 8-word register file addressed by one-hot word selects, with a registered
// read port, an 8-cycle sequential clear engine and illegal-select reporting.
module word_reg_file #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [7:0]        wsel,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [7:0]        rsel,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              clr_req,
  output logic              busy,
  output logic              sel_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] words [8];
  logic [2:0]        cnt;

  logic       accept;
  logic       wsel_ok;
  logic       rsel_ok;
  logic       wr_ok;
  logic       rd_ok;
  logic [2:0] waddr;
  logic [2:0] raddr;

  function automatic logic is_onehot(input logic [7:0] s);
    return (s != 8'd0) && ((s & (s - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [2:0] encode(input logic [7:0] s);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (s[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Ports are only serviced in IDLE when no clear is being requested.
  assign accept  = (state == IDLE) && !clr_req;
  assign wsel_ok = is_onehot(wsel);
  assign rsel_ok = is_onehot(rsel);
  assign wr_ok   = accept && we && wsel_ok;
  assign rd_ok   = accept && re && rsel_ok;
  assign waddr   = encode(wsel);
  assign raddr   = encode(rsel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (clr_req) state_nxt = CLEAR;
      CLEAR: if (cnt == 3'd7) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  // cnt walks 0..7 during CLEAR and naturally wraps back to 0 on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= 3'd0;
    else if (state == CLEAR)  cnt <= cnt + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) words[i] <= '0;
    end else if (state == CLEAR) begin
      words[cnt] <= '0;
    end else if (wr_ok) begin
      words[waddr] <= wdata;
    end
  end

  // rdata samples the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata   <= '0;
      rvalid  <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      rvalid  <= rd_ok;
      sel_err <= accept && ((we && !wsel_ok) || (re && !rsel_ok));
      if (rd_ok) rdata <= words[raddr];
    end
  end

endmodule

// File: tb/tb_word_reg_file.sv
// Directed plus randomized bench for word_reg_file, checked against a
// word-array reference model with a clear countdown.
module tb_word_reg_file;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         we;
  logic [7:0]   wsel;
  logic [W-1:0] wdata;
  logic         re;
  logic [7:0]   rsel;
  logic [W-1:0] rdata;
  logic         rvalid;
  logic         clr_req;
  logic         busy;
  logic         sel_err;

  word_reg_file #(.DATA_W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wsel    (wsel),
    .wdata   (wdata),
    .re      (re),
    .rsel    (rsel),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .clr_req (clr_req),
    .busy    (busy),
    .sel_err (sel_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [W-1:0] mem [8];
  int           clear_left;
  logic [W-1:0] exp_rdata;
  logic         exp_rvalid;
  logic         exp_sel_err;
  logic [W-1:0] exp_q [$];

  int tests;
  int fails;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sel_index(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    clear_left  = 0;
    exp_rdata   = '0;
    exp_rvalid  = 1'b0;
    exp_sel_err = 1'b0;
    exp_q.delete();
  endtask

  // Apply the rules for one rising edge to the model.
  task automatic model_edge();
    bit w_legal, r_legal;
    exp_rvalid  = 1'b0;
    exp_sel_err = 1'b0;
    if (clear_left > 0) begin
      mem[8 - clear_left] = '0;
      clear_left--;
    end else if (clr_req) begin
      clear_left = 8;
    end else begin
      w_legal = ($countones(wsel) == 1);
      r_legal = ($countones(rsel) == 1);
      if (re && r_legal) begin
        exp_rdata  = mem[sel_index(rsel)];
        exp_rvalid = 1'b1;
        exp_q.push_back(exp_rdata);
      end
      if (we && w_legal) mem[sel_index(wsel)] = wdata;
      exp_sel_err = (we && !w_legal) || (re && !r_legal);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] sb;
    check("rvalid", W'(rvalid), W'(exp_rvalid));
    check("rdata", rdata, exp_rdata);
    check("sel_err", W'(sel_err), W'(exp_sel_err));
    check("busy", W'(busy), W'(clear_left > 0));
    if (rvalid === 1'b1 && exp_q.size() > 0) begin
      sb = exp_q.pop_front();
      check("sb_rdata", rdata, sb);
    end
  endtask

  // driver: set inputs away from the edge, advance one edge, then compare
  task automatic step(input logic w, input logic [7:0] ws, input logic [W-1:0] wd,
                      input logic r, input logic [7:0] rs, input logic c);
    we = w; wsel = ws; wdata = wd; re = r; rsel = rs; clr_req = c;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_step();
    step(1'b0, 8'h00, '0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input int i, input logic [W-1:0] d);
    step(1'b1, 8'(1 << i), d, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd(input int i);
    step(1'b0, 8'h00, '0, 1'b1, 8'(1 << i), 1'b0);
  endtask

  function automatic logic [7:0] rand_sel();
    logic [7:0] s;
    if ($urandom_range(0, 3) == 0) s = 8'($urandom_range(0, 255));
    else s = 8'(1 << $urandom_range(0, 7));
    return s;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    we = 0; wsel = 0; wdata = 0; re = 0; rsel = 0; clr_req = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // single write then read of word 3
    wr(3, 8'hA5);
    rd(3);
    idle_step();

    // fill all words, then back-to-back reads
    for (int i = 0; i < 8; i++) wr(i, 8'(8'h10 + i));
    for (int i = 0; i < 8; i++) rd(i);
    idle_step();

    // illegal selects: zero-hot write, multi-hot write, multi-hot read
    step(1'b1, 8'b0000_0000, 8'hEE, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'b0001_0001, 8'hEE, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 8'b1100_0000, 1'b0);
    step(1'b0, 8'h00, '0, 1'b0, 8'b1111_1111, 1'b0);
    rd(0);
    rd(4);
    idle_step();

    // read-before-write on word 5
    wr(5, 8'h33);
    step(1'b1, 8'b0010_0000, 8'h77, 1'b1, 8'b0010_0000, 1'b0);
    rd(5);
    idle_step();

    // clear with a same-cycle write, traffic during busy, then read back
    for (int i = 0; i < 8; i++) wr(i, 8'hFF);
    step(1'b1, 8'b0000_0001, 8'h12, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++)
      step(1'b1, rand_sel(), 8'($urandom), 1'b1, rand_sel(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) rd(i);
    idle_step();

    // reset in the 4th busy cycle of a clear
    for (int i = 0; i < 8; i++) wr(i, 8'(8'hC0 + i));
    rd(6);
    step(1'b0, 8'h00, '0, 1'b0, 8'h00, 1'b1);
    repeat (3) idle_step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    wr(0, 8'h5A);
    rd(0);
    for (int i = 1; i < 8; i++) rd(i);
    idle_step();

    // randomized traffic with occasional clears
    for (int n = 0; n < 300; n++)
      step(1'($urandom_range(0, 1)), rand_sel(), 8'($urandom),
           1'($urandom_range(0, 1)), rand_sel(), ($urandom_range(0, 29) == 0));
    repeat (9) idle_step();
    for (int i = 0; i < 8; i++) rd(i);
    idle_step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_reg_file.md
Name: word_reg_file

Overview:
- 8-word register file, directly downstream of the 3-to-8 address decoder.
- Consumes one-hot word-select lines (decoder `w` outputs) for one write port and one read port.
- Provides registered read data with a valid strobe, a sequential clear engine, and detection of illegal (non-one-hot) selects.
- Used as the small storage array fed by the decoded address bus.

Parameters:
- DATA_W, 8, width of each stored word in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- wsel  in  8  one-hot write word select; bit i selects word i.
- wdata  in  DATA_W  write data.
- re  in  1  read enable.
- rsel  in  8  one-hot read word select.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  one-cycle pulse; rdata is updated this cycle.
- clr_req  in  1  request to zero all 8 words.
- busy  out  1  high while the clear sequence runs.
- sel_err  out  1  one-cycle pulse on an illegal select.

Behaviour:
- One clock domain. Reset is asynchronous, active-low: asserting rst_n=0 immediately forces all of the following:
  - words[0..7] = 0, rdata = 0, rvalid = 0, busy = 0, sel_err = 0.
  - FSM = IDLE, clear counter = 0.
- FSM states:
  - IDLE → CLEAR when clr_req=1 at a rising edge.
  - CLEAR → IDLE after the edge that zeroes word 7.
- Legal select: exactly one bit of the select vector is high. Zero-hot and multi-hot are illegal.
- Write (IDLE, clr_req=0, we=1):
  - Legal wsel: word[i] <= wdata at the edge.
  - Illegal wsel: no word is modified.
- Read (IDLE, clr_req=0, re=1):
  - Legal rsel: rdata <= word[i] and rvalid=1 in the following cycle (1-cycle latency).
  - Illegal rsel: rvalid stays 0 and rdata holds its value.
- rvalid is high for exactly one cycle per accepted read. Back-to-back reads give back-to-back rvalid.
- rdata holds its last value when no read is accepted.
- Read and write to the same word in the same cycle: read returns the OLD contents (read-before-write). The new value is visible from the next read onward.
- sel_err is registered:
  - It is 1 in the cycle after any accepted-state cycle with (we=1 and wsel illegal) or (re=1 and rsel illegal); both ports are ORed.
  - It is 0 otherwise.
  - No sel_err while the enable is low, regardless of the select value.
- Clear sequence:
  - clr_req has priority over we/re in the same IDLE cycle; we/re are ignored that cycle.
  - From the next cycle, busy=1 for exactly 8 cycles. In each cycle, word[cnt] <= 0 at the edge, with cnt counting 0→7.
  - busy drops the cycle after word 7 is cleared.
  - cnt is 3 bits, wraps to 0 at exit, and is reset to 0.
- During CLEAR:
  - we, re and clr_req are ignored; no writes, no rvalid, no sel_err.
  - rdata holds its value.
- Reset asserted mid-clear: state returns to IDLE, busy=0, all words=0 immediately. No residual clear continues after reset release.
- First operation is accepted on the first rising edge after rst_n deasserts.

Test Plan:
1. Reset, then write 0xA5 to word 3 (wsel=8'b0000_1000), then read word 3 → rvalid=1 one cycle after the read, rdata=0xA5, sel_err=0.
2. Write distinct values 0x10..0x17 to words 0..7, then read all 8 back-to-back → rvalid high for 8 consecutive cycles, rdata=0x10..0x17 in order.
3. Illegal selects: we=1 with wsel=8'b0000_0000, then we=1 with wsel=8'b0001_0001, then re=1 with rsel=8'b1100_0000 → sel_err pulses one cycle after each, no word changes (re-read shows prior values), rvalid stays 0 for the illegal read.
4. Same-cycle read+write: word 5 holds 0x33; write 0x77 to word 5 while reading word 5 → rdata=0x33; next read gives 0x77.
5. Clear: fill all words with 0xFF, assert clr_req with we=1 in the same cycle → write is ignored, busy=1 for exactly 8 cycles, and reads/writes issued during busy produce no rvalid and no change. After busy falls, reading all 8 words returns 0x00.
6. Assert rst_n=0 in the 4th cycle of a clear → busy=0 and rdata=0 immediately. After release, all words read 0 and a write/read of 0x5A to word 0 works on the first edge.
